// File: rtl/core_reset_seq_pkg.sv
// Shared types and constants for the core reset sequencer.
// Phase constants describe the 12-cycle strobe frame at 96 MHz:
// 32 MHz enables on every third phase, 8 MHz enable at phase 0,
// and a quadrature 8 MHz enable three phases later.
package core_reset_seq_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StStable   = 2'd1,
    StHold     = 2'd2,
    StRun      = 2'd3
  } core_rst_state_t;

  localparam logic [3:0]  PHASE_LAST = 4'd11;
  localparam logic [3:0]  PHASE_CE8  = 4'd0;
  localparam logic [3:0]  PHASE_CE8Q = 4'd3;
  localparam int unsigned CE32_DIV   = 3;

  // True on the phases where the 32 MHz enable fires.
  function automatic logic is_ce32_phase(input logic [3:0] phase);
    return (32'(phase) % CE32_DIV) == 32'd0;
  endfunction

endpackage

// File: rtl/core_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous flag.
// The last stage is the synchronized output; all stages clear on reset.
module core_sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/core_reset_seq.sv
// Reset sequencer and clock-enable generator downstream of the core PLL.
// Waits for a stable lock, starts the 32 MHz / 8 MHz enables, holds the
// game core in reset for a fixed interval, then releases it. Any lock loss
// drops back to waiting with the core in reset and the enables stopped.
// Optional: define CORE_RESET_LOCK_LOSS_CNT_EN to count lock losses seen
// while running (saturating 8-bit); otherwise lock_loss_cnt reads 0.
module core_reset_seq
  import core_reset_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       locked_sync,
  output logic       ce_32,
  output logic       ce_8,
  output logic       ce_8_q,
  output logic       core_reset_n,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  core_rst_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic             run_q, run_d;

  core_sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_sync)
  );

  // Next-state and interval counter; lock drop beats a counter terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (locked_sync) begin
          state_d = StStable;
        end
      end
      StStable: begin
        if (!locked_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (!locked_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (!locked_sync) begin
          state_d = StWaitLock;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes run in HOLD and RUN only.
  assign run_q = (state_q == StHold) || (state_q == StRun);
  assign run_d = (state_d == StHold) || (state_d == StRun);

  // Phase restarts at 0 on HOLD entry and free-runs across HOLD->RUN so the
  // enables keep an exact period through the reset release.
  always_comb begin
    phase_d = 4'd0;
    if (run_d && run_q) begin
      phase_d = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
    end
  end

  // Sequencer state, counter and phase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      phase_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_reset_n <= 1'b0;
      ce_32        <= 1'b0;
      ce_8         <= 1'b0;
      ce_8_q       <= 1'b0;
    end else begin
      core_reset_n <= (state_d == StRun);
      ce_32        <= run_d && is_ce32_phase(phase_d);
      ce_8         <= run_d && (phase_d == PHASE_CE8);
      ce_8_q       <= run_d && (phase_d == PHASE_CE8Q);
    end
  end

`ifdef CORE_RESET_LOCK_LOSS_CNT_EN
  logic       loss_evt;
  logic [7:0] loss_cnt_q;

  assign loss_evt = (state_q == StRun) && !locked_sync;

  // Saturating count of lock losses taken while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else if (loss_evt && (loss_cnt_q != 8'hff)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_core_reset_seq.sv
// Bench for core_reset_seq with STABLE_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2.
// The reference model counts consecutive edges at which the synchronized
// lock was high and derives every output from that count arithmetically.
module tb_core_reset_seq;
  import core_reset_seq_pkg::*;

  localparam int S  = 8;
  localparam int H  = 4;
  localparam int SS = 2;
`ifdef CORE_RESET_LOCK_LOSS_CNT_EN
  localparam bit LLC_EN = 1'b1;
`else
  localparam bit LLC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       locked_sync;
  logic       ce_32;
  logic       ce_8;
  logic       ce_8_q;
  logic       core_reset_n;
  logic [7:0] lock_loss_cnt;

  core_reset_seq #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .locked_sync   (locked_sync),
    .ce_32         (ce_32),
    .ce_8          (ce_8),
    .ce_8_q        (ce_8_q),
    .core_reset_n  (core_reset_n),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_run = consecutive edges with synchronized lock high.
  int          m_run  = 0;
  logic [SS-1:0] m_dl = '0;
  int          m_loss = 0;

  typedef struct {
    logic       rst_n;
    logic       pll_locked;
    logic [4:0] exp;  // {locked_sync, ce_32, ce_8, ce_8_q, core_reset_n}
  } vec_t;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      m_run  = 0;
      m_dl   = '0;
      m_loss = 0;
    end else begin
      if (m_dl[SS-1]) begin
        m_run++;
      end else begin
        if (LLC_EN && (m_run >= S + H + 1) && (m_loss < 255)) m_loss++;
        m_run = 0;
      end
      m_dl = {m_dl[SS-2:0], pll_locked};
    end
  endfunction

  function automatic logic [12:0] model_out();
    logic c32, c8, c8q;
    int   p;
    c32 = 1'b0;
    c8  = 1'b0;
    c8q = 1'b0;
    if (m_run >= S + 1) begin
      p   = (m_run - S - 1) % 12;
      c32 = (p % 3) == 0;
      c8  = (p == 0);
      c8q = (p == 3);
    end
    return {m_dl[SS-1], c32, c8, c8q, (m_run >= S + H + 1), 8'(m_loss)};
  endfunction

  function automatic logic [12:0] dut_out();
    return {locked_sync, ce_32, ce_8, ce_8_q, core_reset_n, lock_loss_cnt};
  endfunction

  task automatic tick(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[23];
    int   first_rise;
    int   n;
    int   n32, n8, last32, last8;

    rst_n      = 1'b0;
    pll_locked = 1'b1;

    // Power-up table: 5 reset cycles, then release with lock held high.
    for (int i = 0; i < 23; i++) begin
      vecs[i].rst_n      = (i >= 5);
      vecs[i].pll_locked = 1'b1;
      vecs[i].exp        = (i >= 6) ? 5'b10000 : 5'b00000;
    end
    vecs[15].exp = 5'b11100;  // first HOLD cycle: ce_32 + ce_8
    vecs[18].exp = 5'b11010;  // phase 3: ce_32 + ce_8_q
    vecs[19].exp = 5'b10001;  // core released 14 edges after release edge
    vecs[20].exp = 5'b10001;
    vecs[21].exp = 5'b11001;
    vecs[22].exp = 5'b10001;

    first_rise = -1;
    for (int i = 0; i < 23; i++) begin
      rst_n      = vecs[i].rst_n;
      pll_locked = vecs[i].pll_locked;
      tick("powerup_model");
      check($sformatf("powerup_vec%0d", i),
            32'({locked_sync, ce_32, ce_8, ce_8_q, core_reset_n}), 32'(vecs[i].exp));
      if (i < 5) check("powerup_loss_cnt", 32'(lock_loss_cnt), 32'd0);
      if ((core_reset_n === 1'b1) && (first_rise < 0)) first_rise = i;
    end
    check("powerup_rise_edges", 32'(first_rise - 5), 32'd14);

    // Lock glitch mid-STABLE restarts the full stable count.
    rst_n = 1'b0;
    repeat (2) tick("glitch_reset");
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    repeat (6) tick("glitch_stable");
    check("glitch_in_stable", 32'(dut.state_q), 32'(StStable));
    pll_locked = 1'b0;
    repeat (3) tick("glitch_low");
    check("glitch_wait_lock", 32'(dut.state_q), 32'(StWaitLock));
    pll_locked = 1'b1;
    n = 0;
    while ((core_reset_n !== 1'b1) && (n < 40)) begin
      tick("glitch_reacquire");
      n++;
    end
    check("glitch_restart_edges", 32'(n), 32'd15);

    // Strobe cadence in RUN over 120 cycles.
    n32 = 0;
    n8 = 0;
    last32 = -1;
    last8 = -1;
    for (int t = 0; t < 120; t++) begin
      tick("run_strobe");
      if (ce_32 === 1'b1) begin
        if (last32 >= 0) check("ce32_period", 32'(t - last32), 32'd3);
        last32 = t;
        n32++;
      end
      if (ce_8 === 1'b1) begin
        if (last8 >= 0) check("ce8_period", 32'(t - last8), 32'd12);
        last8 = t;
        n8++;
      end
      if ((ce_8_q === 1'b1) && (last8 >= 0)) check("ce8q_offset", 32'(t - last8), 32'd3);
    end
    check("ce32_count", 32'(n32), 32'd40);
    check("ce8_count", 32'(n8), 32'd10);

    // Lock loss in RUN: core reset and strobes drop 3 edges after the fall.
    pll_locked = 1'b0;
    repeat (2) tick("loss_prop");
    check("loss_crn_still_high", 32'(core_reset_n), 32'd1);
    tick("loss_drop");
    check("loss_outputs_low", 32'({core_reset_n, ce_32, ce_8, ce_8_q}), 32'd0);
    check("loss_cnt_step", 32'(lock_loss_cnt), LLC_EN ? 32'd1 : 32'd0);
    repeat (12) tick("loss_quiet");
    check("loss_strobes_stopped", 32'({ce_32, ce_8, ce_8_q}), 32'd0);

    // Saturation: 260 further RUN->lock-loss cycles.
    for (int k = 0; k < 260; k++) begin
      pll_locked = 1'b1;
      repeat (16) tick("sat_acquire");
      pll_locked = 1'b0;
      repeat (3) tick("sat_drop");
    end
    check("sat_cnt", 32'(lock_loss_cnt), LLC_EN ? 32'd255 : 32'd0);
    rst_n = 1'b0;
    tick("sat_reset");
    check("sat_cleared", 32'(lock_loss_cnt), 32'd0);

    // Reset asserted on the second HOLD cycle.
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    repeat (12) tick("hold_reach");
    check("hold_reached", 32'(dut.state_q), 32'(StHold));
    rst_n = 1'b0;
    tick("hold_reset");
    check("hold_reset_outputs",
          32'({locked_sync, ce_32, ce_8, ce_8_q, core_reset_n, lock_loss_cnt}), 32'd0);
    check("hold_reset_phase", 32'(dut.phase_q), 32'd0);
    check("hold_reset_state", 32'(dut.state_q), 32'(StWaitLock));

    // Randomized lock behaviour with occasional resets.
    rst_n = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (pll_locked) begin
        if ($urandom_range(0, 39) == 0) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) pll_locked = 1'b1;
      end
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
